// File: rtl/reload_timer.sv
// reload_timer: run-time loadable down-counter with a fixed prescaler.
// It supports one-shot or periodic reload, a one-cycle expiry pulse, and
// sticky irq/missed flags.
module reload_timer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_srst,
    input  logic             i_en,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_load_periodic,
    input  logic             i_stop,
    input  logic             i_irq_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_expire,
    output logic             o_irq,
    output logic             o_missed
);

    localparam int unsigned PW = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("reload_timer: PRESCALE must be at least 1");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("reload_timer: WIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [PW-1:0]    r_presc;
    logic             r_periodic;
    logic             r_expire;
    logic             r_irq;
    logic             r_missed;

    logic w_load_acc;
    logic w_tick;
    logic w_expire_now;

    // Decode load acceptance, prescaler tick and expiry for this cycle.
    // stop suppresses the tick so an abort never races an expiry.
    always_comb begin
        o_load_ready = (r_state == S_IDLE) && !i_stop;
        w_load_acc   = o_load_ready && i_load_valid;
        w_tick       = (r_state == S_RUN) && !i_stop && i_en && (r_presc == PS_LAST);
        w_expire_now = (w_load_acc && (i_load_value == '0)) ||
                       (w_tick && (r_count == WIDTH'(1)));
    end

    // Timer FSM with registered outputs and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_presc    <= '0;
            r_periodic <= 1'b0;
            r_expire   <= 1'b0;
            r_irq      <= 1'b0;
            r_missed   <= 1'b0;
        end else if (i_srst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_presc    <= '0;
            r_periodic <= 1'b0;
            r_expire   <= 1'b0;
            r_irq      <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            r_expire <= w_expire_now;

            // A set takes priority over a clear in the same cycle.
            if (w_expire_now) begin
                r_irq <= 1'b1;
            end else if (i_irq_clr) begin
                r_irq <= 1'b0;
            end

            if (w_expire_now && r_irq && !i_irq_clr) begin
                r_missed <= 1'b1;
            end else if (i_irq_clr) begin
                r_missed <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_load_acc) begin
                        r_reload   <= i_load_value;
                        r_periodic <= i_load_periodic;
                        r_presc    <= '0;
                        r_count    <= i_load_value;
                        if (i_load_value != '0) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        r_presc <= '0;
                    end else if (i_en) begin
                        if (w_tick) begin
                            r_presc <= '0;
                            if (r_count != WIDTH'(1)) begin
                                r_count <= r_count - WIDTH'(1);
                            end else if (r_periodic) begin
                                r_count <= r_reload;
                            end else begin
                                r_count <= '0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_count  = r_count;
    assign o_busy   = (r_state == S_RUN);
    assign o_expire = r_expire;
    assign o_irq    = r_irq;
    assign o_missed = r_missed;

endmodule

// File: tb/tb_reload_timer.sv
// Directed self-checking bench for reload_timer (PRESCALE=1 and PRESCALE=4 instances).
module tb_reload_timer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         srst = 1'b0;
    logic         en = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         load_periodic = 1'b0;
    logic         stop = 1'b0;
    logic         irq_clr = 1'b0;

    logic         rdy1, busy1, exp1, irq1, mis1;
    logic [W-1:0] cnt1;
    logic         rdy4, busy4, exp4, irq4, mis4;
    logic [W-1:0] cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reload_timer #(.WIDTH(W), .PRESCALE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_srst(srst), .i_en(en),
        .i_load_valid(load_valid), .o_load_ready(rdy1), .i_load_value(load_value),
        .i_load_periodic(load_periodic), .i_stop(stop), .i_irq_clr(irq_clr),
        .o_count(cnt1), .o_busy(busy1), .o_expire(exp1), .o_irq(irq1), .o_missed(mis1)
    );

    reload_timer #(.WIDTH(W), .PRESCALE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .i_srst(srst), .i_en(en),
        .i_load_valid(load_valid), .o_load_ready(rdy4), .i_load_value(load_value),
        .i_load_periodic(load_periodic), .i_stop(stop), .i_irq_clr(irq_clr),
        .o_count(cnt4), .o_busy(busy4), .o_expire(exp4), .o_irq(irq4), .o_missed(mis4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        srst = 0; en = 0; load_valid = 0; load_value = '0;
        load_periodic = 0; stop = 0; irq_clr = 0;
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy1); end
        checks++; if (exp1 !== 1'b0) begin errors++; $display("FAIL reset_expire got %b exp 0", exp1); end
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq1); end
        checks++; if (mis1 !== 1'b0) begin errors++; $display("FAIL reset_missed got %b exp 0", mis1); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", rdy1); end
    endtask

    task automatic test_oneshot();
        do_reset();
        en = 1; load_valid = 1; load_value = 8'd5; load_periodic = 0;
        step();
        load_valid = 0;
        checks++; if (cnt1 !== 8'd5) begin errors++; $display("FAIL os_load_count got %0d exp 5", cnt1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL os_load_busy got %b exp 1", busy1); end
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++; if (cnt1 !== W'(5 - k)) begin errors++; $display("FAIL os_count k=%0d got %0d exp %0d", k, cnt1, 5 - k); end
            checks++; if (exp1 !== (k == 5)) begin errors++; $display("FAIL os_expire k=%0d got %b exp %b", k, exp1, k == 5); end
            checks++; if (busy1 !== (k < 5)) begin errors++; $display("FAIL os_busy k=%0d got %b exp %b", k, busy1, k < 5); end
        end
        checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL os_irq_set got %b exp 1", irq1); end
        step();
        checks++; if (exp1 !== 1'b0) begin errors++; $display("FAIL os_expire_single got %b exp 0", exp1); end
        checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL os_irq_sticky got %b exp 1", irq1); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL os_ready_after got %b exp 1", rdy1); end
        irq_clr = 1;
        step();
        irq_clr = 0;
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL os_irq_clr got %b exp 0", irq1); end
    endtask

    task automatic test_periodic();
        do_reset();
        en = 1; load_valid = 1; load_value = 8'd3; load_periodic = 1;
        step();
        load_valid = 0;
        checks++; if (cnt4 !== 8'd3) begin errors++; $display("FAIL per_load_count got %0d exp 3", cnt4); end
        for (int k = 1; k <= 24; k++) begin
            step();
            checks++; if (cnt4 !== W'(3 - ((k / 4) % 3))) begin errors++; $display("FAIL per_count k=%0d got %0d exp %0d", k, cnt4, 3 - ((k / 4) % 3)); end
            checks++; if (exp4 !== ((k % 12) == 0)) begin errors++; $display("FAIL per_expire k=%0d got %b exp %b", k, exp4, (k % 12) == 0); end
            checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL per_busy k=%0d got %b exp 1", k, busy4); end
        end
        // Seven disabled cycles after two enabled ones push the next expiry from 12 to 19.
        for (int c = 1; c <= 19; c++) begin
            en = !(c >= 3 && c <= 9);
            step();
            checks++; if (exp4 !== (c == 19)) begin errors++; $display("FAIL per_pause_expire c=%0d got %b exp %b", c, exp4, c == 19); end
        end
        en = 1;
        checks++; if (cnt4 !== 8'd3) begin errors++; $display("FAIL per_pause_count got %0d exp 3", cnt4); end
    endtask

    task automatic test_stop();
        do_reset();
        en = 1; load_valid = 1; load_value = 8'd5; load_periodic = 0;
        step();
        load_valid = 0;
        step(); step(); step();
        checks++; if (cnt1 !== 8'd2) begin errors++; $display("FAIL stop_pre_count got %0d exp 2", cnt1); end
        stop = 1; load_valid = 1; load_value = 8'd7;
        step();
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL stop_count got %0d exp 0", cnt1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL stop_busy got %b exp 0", busy1); end
        checks++; if (exp1 !== 1'b0) begin errors++; $display("FAIL stop_expire got %b exp 0", exp1); end
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL stop_irq got %b exp 0", irq1); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL stop_ready_held got %b exp 0", rdy1); end
        step();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL stop_no_load got %b exp 0", busy1); end
        stop = 0;
        #1;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL stop_ready_release got %b exp 1", rdy1); end
        step();
        load_valid = 0;
        checks++; if (cnt1 !== 8'd7) begin errors++; $display("FAIL stop_reload_count got %0d exp 7", cnt1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL stop_reload_busy got %b exp 1", busy1); end
    endtask

    task automatic test_load_zero();
        do_reset();
        en = 1; load_valid = 1; load_value = 8'd0; load_periodic = 1;
        step();
        checks++; if (exp1 !== 1'b1) begin errors++; $display("FAIL z_expire got %b exp 1", exp1); end
        checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL z_irq got %b exp 1", irq1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL z_busy got %b exp 0", busy1); end
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL z_count got %0d exp 0", cnt1); end
        checks++; if (mis1 !== 1'b0) begin errors++; $display("FAIL z_missed_first got %b exp 0", mis1); end
        step();
        checks++; if (exp1 !== 1'b1) begin errors++; $display("FAIL z_expire2 got %b exp 1", exp1); end
        checks++; if (mis1 !== 1'b1) begin errors++; $display("FAIL z_missed_set got %b exp 1", mis1); end
        irq_clr = 1;
        step();
        checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL z_irq_set_wins got %b exp 1", irq1); end
        checks++; if (mis1 !== 1'b0) begin errors++; $display("FAIL z_missed_clr got %b exp 0", mis1); end
        load_valid = 0; irq_clr = 0;
        step();
        checks++; if (exp1 !== 1'b0) begin errors++; $display("FAIL z_expire_idle got %b exp 0", exp1); end
        checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL z_irq_hold got %b exp 1", irq1); end
    endtask

    task automatic test_srst();
        do_reset();
        en = 1; load_valid = 1; load_value = 8'd3; load_periodic = 1;
        step();
        load_valid = 0;
        for (int k = 0; k < 5; k++) step();
        checks++; if (cnt4 !== 8'd2) begin errors++; $display("FAIL srst_pre_count got %0d exp 2", cnt4); end
        srst = 1;
        step();
        srst = 0;
        checks++; if (cnt4 !== 8'd0) begin errors++; $display("FAIL srst_count got %0d exp 0", cnt4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL srst_busy got %b exp 0", busy4); end
        checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL srst_irq got %b exp 0", irq4); end
        checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL srst_ready got %b exp 1", rdy4); end
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++; if (exp4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL srst_quiet k=%0d got expire=%b busy=%b exp 0 0", k, exp4, busy4); end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop();
        test_load_zero();
        test_srst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
